ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 138 +++++++++++++
 tb/tb_ram_responder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_responder
// Description : Word-addressed RAM model that answers a memory controller
//               with a FREE/BUSY/ACCESS/ERROR handshake. Every legal access
//               shows BUSY for LAT cycles, then ACCESS for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 16384
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  // Word-index width; a legal byte address lies entirely within [AW+1:2].
  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(longint'(DEPTH) * 4);
  localparam logic [3:0]  CNT_INIT   = 4'(LAT - 1);

  // State encoding equals the ramstate code so the output is a pure decode.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;
  logic            lat_wen;
  logic [AW-1:0]   lat_idx;
  logic [31:0]     lat_data;
  logic            latch_req;
  logic            do_access;
  logic            req_any;
  logic            req_valid;
  logic            req_same;
  logic [31:0]     mem [DEPTH];

  // A legal request is one-hot REN/WEN, word-aligned and inside the array.
  // Since a legal address has no bits outside [AW+1:2], comparing the word
  // index alone is enough to decide that a legal request is unchanged.
  assign req_any   = ramREN | ramWEN;
  assign req_valid = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00) &&
                     ({1'b0, ramaddr} < BYTE_LIMIT);
  assign req_same  = req_valid && (ramWEN == lat_wen) &&
                     (ramaddr[AW+1:2] == lat_idx) &&
                     (!ramWEN || (ramstore == lat_data));

  assign ramstate = state;

  // Next-state, counter and access strobe decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch_req = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          latch_req = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = WAIT;
        end else if (req_any) begin
          state_nxt = ERR;
        end
      end
      WAIT: begin
        if (req_same) begin
          if (cnt == 4'd0) begin
            do_access = 1'b1;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end else if (req_valid) begin
          // A different legal request restarts the full latency.
          latch_req = 1'b1;
          cnt_nxt   = CNT_INIT;
        end else if (req_any) begin
          state_nxt = ERR;
        end else begin
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and read-data registers; reset overrides any request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ramload <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (do_access && !lat_wen) begin
        ramload <= mem[lat_idx];
      end
    end
  end

  // Capture the request that the pending access will perform.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lat_wen  <= 1'b0;
      lat_idx  <= '0;
      lat_data <= 32'd0;
    end else if (latch_req) begin
      lat_wen  <= ramWEN;
      lat_idx  <= ramaddr[AW+1:2];
      lat_data <= ramstore;
    end
  end

  // Storage array; reset leaves contents intact and blocks a pending write.
  always_ff @(posedge CLK) begin
    if (!RST && do_access && lat_wen) begin
      mem[lat_idx] <= lat_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_responder
// Description : Self-checking bench for ram_responder. Three instances
//               (LAT=2/DEPTH=16384, LAT=3/DEPTH=64, LAT=1/DEPTH=64) are
//               compared each cycle against a behavioural model, plus
//               directed checks with hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

  localparam logic [1:0] S_FREE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_ACC  = 2'b10;
  localparam logic [1:0] S_ERR  = 2'b11;
  localparam int         TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [31:0] ld    [3];
  logic [1:0]  st    [3];

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  ram_responder #(.LAT(2), .DEPTH(16384)) u0 (
    .CLK(clk), .RST(rst), .ramREN(ren[0]), .ramWEN(wen[0]),
    .ramaddr(addr[0]), .ramstore(store[0]), .ramload(ld[0]), .ramstate(st[0])
  );
  ram_responder #(.LAT(3), .DEPTH(64)) u1 (
    .CLK(clk), .RST(rst), .ramREN(ren[1]), .ramWEN(wen[1]),
    .ramaddr(addr[1]), .ramstore(store[1]), .ramload(ld[1]), .ramstate(st[1])
  );
  ram_responder #(.LAT(1), .DEPTH(64)) u2 (
    .CLK(clk), .RST(rst), .ramREN(ren[2]), .ramWEN(wen[2]),
    .ramaddr(addr[2]), .ramstore(store[2]), .ramload(ld[2]), .ramstate(st[2])
  );

  // ---------------------------------------------------------------- model
  function automatic int lat_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 1);
  endfunction

  function automatic longint depth_of(int i);
    return (i == 0) ? 64'd16384 : 64'd64;
  endfunction

  function automatic int base_of(int i);
    return (i == 0) ? 0 : ((i == 1) ? 16384 : 16448);
  endfunction

  logic [1:0]  m_mode [3];
  int          m_left [3];
  logic        m_wen  [3];
  logic [31:0] m_addr [3];
  logic [31:0] m_data [3];
  logic [31:0] m_load [3];
  logic [31:0] m_mem  [0:16511];

  initial begin
    for (int k = 0; k < 16512; k++) m_mem[k] = 32'd0;
  end

  function automatic bit m_valid(int i);
    return ((ren[i] ^ wen[i]) == 1'b1) && (addr[i][1:0] == 2'b00) &&
           (longint'(addr[i]) < depth_of(i) * 4);
  endfunction

  function automatic bit m_same(int i);
    return m_valid(i) && (wen[i] == m_wen[i]) && (addr[i] == m_addr[i]) &&
           (!wen[i] || (store[i] == m_data[i]));
  endfunction

  // Model: counts remaining busy cycles of the current request.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_mode[i] <= S_FREE;
        m_left[i] <= 0;
        m_load[i] <= 32'd0;
      end else begin
        case (m_mode[i])
          S_FREE: begin
            if (m_valid(i)) begin
              m_wen[i]  <= wen[i];
              m_addr[i] <= addr[i];
              m_data[i] <= store[i];
              m_left[i] <= lat_of(i);
              m_mode[i] <= S_BUSY;
            end else if (ren[i] || wen[i]) begin
              m_mode[i] <= S_ERR;
            end
          end
          S_BUSY: begin
            if (m_same(i)) begin
              if (m_left[i] == 1) begin
                m_mode[i] <= S_ACC;
                if (m_wen[i])
                  m_mem[base_of(i) + int'(m_addr[i] >> 2)] <= m_data[i];
                else
                  m_load[i] <= m_mem[base_of(i) + int'(m_addr[i] >> 2)];
              end else begin
                m_left[i] <= m_left[i] - 1;
              end
            end else if (m_valid(i)) begin
              m_wen[i]  <= wen[i];
              m_addr[i] <= addr[i];
              m_data[i] <= store[i];
              m_left[i] <= lat_of(i);
            end else if (ren[i] || wen[i]) begin
              m_mode[i] <= S_ERR;
            end else begin
              m_mode[i] <= S_FREE;
            end
          end
          default: m_mode[i] <= S_FREE;
        endcase
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (st[i] !== m_mode[i]) begin
          bad++;
          $display("FAIL model_state[%0d] t=%0t actual=%0d required=%0d", i, $time, st[i], m_mode[i]);
        end
        total++;
        if (ld[i] !== m_load[i]) begin
          bad++;
          $display("FAIL model_load[%0d] t=%0t actual=%h required=%h", i, $time, ld[i], m_load[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int i, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    ren[i] = r; wen[i] = w; addr[i] = a; store[i] = d;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Wait (bounded) for ACCESS on instance i, counting BUSY cycles on the way.
  task automatic wait_access(input int i, output int nbusy, output logic [31:0] load);
    bit done = 1'b0;
    nbusy = 0;
    load  = 32'd0;
    for (int n = 0; n < TIMEOUT && !done; n++) begin
      tick();
      if (st[i] == S_BUSY) nbusy++;
      else if (st[i] == S_ACC) begin
        done = 1'b1;
        load = ld[i];
      end
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_access(input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, output int nbusy, output logic [31:0] load);
    drive(i, !w, w, a, d);
    wait_access(i, nbusy, load);
    idle(i);
    tick();
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d, input int exp_busy);
    int nb;
    logic [31:0] l;
    do_access(i, 1'b1, a, d, nb, l);
    check("write_busy_cycles", 32'(nb), 32'(exp_busy));
  endtask

  task automatic rd(input int i, input logic [31:0] a, input logic [31:0] exp,
                    input int exp_busy, input string name);
    int nb;
    logic [31:0] l;
    do_access(i, 1'b0, a, 32'd0, nb, l);
    check({name, "_busy"}, 32'(nb), 32'(exp_busy));
    check(name, l, exp);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [1:0]  seq [5];
    logic [1:0]  exp_seq [5];
    int          nb;
    logic [31:0] l;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle(i);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("reset_state", 32'(st[i]), 32'(S_FREE));
      check("reset_load", ld[i], 32'd0);
    end
    chk_on = 1'b1;
    rst = 1'b0;
    tick();

    // Write held at LAT=2: FREE,BUSY,BUSY,ACCESS,FREE.
    exp_seq = '{S_FREE, S_BUSY, S_BUSY, S_ACC, S_FREE};
    drive(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    seq[0] = st[0];
    for (int k = 1; k < 5; k++) begin
      tick();
      seq[k] = st[0];
      if (k == 3) idle(0);
    end
    for (int k = 0; k < 5; k++) check("write_seq", 32'(seq[k]), 32'(exp_seq[k]));
    rd(0, 32'h100, 32'hDEADBEEF, 2, "read_0x100");

    // Illegal requests: both enables, misaligned, out of range.
    drive(0, 1'b1, 1'b1, 32'h100, 32'h55);
    tick(); check("err_both", 32'(st[0]), 32'(S_ERR));
    idle(0);
    tick(); check("err_both_free", 32'(st[0]), 32'(S_FREE));
    drive(0, 1'b0, 1'b1, 32'h3, 32'h77);
    tick(); check("err_misaligned", 32'(st[0]), 32'(S_ERR));
    idle(0);
    tick(); check("err_mis_free", 32'(st[0]), 32'(S_FREE));
    drive(0, 1'b0, 1'b1, 32'h10000, 32'h99);
    tick(); check("err_range", 32'(st[0]), 32'(S_ERR));
    check("err_keeps_load", ld[0], 32'hDEADBEEF);
    idle(0);
    tick();
    rd(0, 32'h100, 32'hDEADBEEF, 2, "read_after_err");

    // Reset during the second BUSY cycle aborts the write.
    wr(0, 32'h40, 32'hAAAA0040, 2);
    drive(0, 1'b0, 1'b1, 32'h40, 32'h12345678);
    tick();
    tick(); check("rst_mid_busy", 32'(st[0]), 32'(S_BUSY));
    rst = 1'b1;
    tick();
    check("rst_state", 32'(st[0]), 32'(S_FREE));
    check("rst_load", ld[0], 32'd0);
    // Request present in the first cycle after reset is accepted at once.
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h40, 32'd0);
    tick(); check("accept_after_rst", 32'(st[0]), 32'(S_BUSY));
    tick();
    tick(); check("rst_read_state", 32'(st[0]), 32'(S_ACC));
    check("rst_read_old", ld[0], 32'hAAAA0040);
    idle(0);
    tick();

    // Address change mid-wait at LAT=3.
    wr(1, 32'h10, 32'h11110010, 3);
    wr(1, 32'h20, 32'hCAFE0020, 3);
    drive(1, 1'b1, 1'b0, 32'h10, 32'd0);
    tick(); check("chg_busy0", 32'(st[1]), 32'(S_BUSY));
    drive(1, 1'b1, 1'b0, 32'h20, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); check("chg_busy", 32'(st[1]), 32'(S_BUSY));
    end
    tick(); check("chg_access", 32'(st[1]), 32'(S_ACC));
    check("chg_load", ld[1], 32'hCAFE0020);
    idle(1);
    tick();

    // Write data change mid-wait restarts latency; last data wins.
    drive(1, 1'b0, 1'b1, 32'h30, 32'h1);
    tick();
    drive(1, 1'b0, 1'b1, 32'h30, 32'h2);
    wait_access(1, nb, l);
    check("data_chg_busy", 32'(nb), 32'd3);
    idle(1);
    tick();
    rd(1, 32'h30, 32'h2, 3, "data_chg_read");

    // Illegal address and dropped request during WAIT leave memory alone.
    drive(1, 1'b0, 1'b1, 32'h10, 32'h999);
    tick();
    drive(1, 1'b0, 1'b1, 32'h12, 32'h999);
    tick(); check("wait_illegal", 32'(st[1]), 32'(S_ERR));
    idle(1);
    tick();
    drive(1, 1'b0, 1'b1, 32'h10, 32'h888);
    tick(); tick();
    idle(1);
    tick(); check("wait_drop", 32'(st[1]), 32'(S_FREE));
    rd(1, 32'h10, 32'h11110010, 3, "wait_abort_read");

    // Held read at LAT=1: repeating FREE,BUSY,ACCESS.
    wr(2, 32'h8, 32'h0BADF00D, 1);
    drive(2, 1'b1, 1'b0, 32'h8, 32'd0);
    for (int k = 0; k < 9; k++) begin
      check("held_seq", 32'(st[2]), (k % 3 == 0) ? 32'(S_FREE) :
                                    ((k % 3 == 1) ? 32'(S_BUSY) : 32'(S_ACC)));
      if (k % 3 == 2) check("held_load", ld[2], 32'h0BADF00D);
      tick();
    end
    idle(2);
    tick();

    // Boundary addresses, no aliasing, neighbours untouched.
    wr(0, 32'h0, 32'h0000AAAA, 2);
    wr(0, 32'hFFFC, 32'hFFFF5555, 2);
    rd(0, 32'h0, 32'h0000AAAA, 2, "bound_lo");
    rd(0, 32'hFFFC, 32'hFFFF5555, 2, "bound_hi");
    rd(0, 32'h100, 32'hDEADBEEF, 2, "neighbour");

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
